spi_cfg_ctrl: RTL and testbench

SPI-slave configuration controller between the SAMD51 SPI link (cfg_cs/cfg_si/cfg_sck/cfg_so) and the on-chip waveform/PDM channels.
- Oversamples SPI on the 48 MHz clk and decodes 24-bit frames into a register bank.
- Stages channel settings in shadow registers.
- Commits them atomically to the active channel outputs at frame end, so saw/pdm channels never see a half-written configuration.

---
 rtl/spi_cfg_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_spi_cfg_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_ctrl.sv
// SPI-slave configuration controller.
// Oversamples a mode-0 SPI link on clk, decodes 24-bit frames (rw, addr[6:0], data[15:0])
// into shadow registers and commits all shadows to the active channel outputs at once
// after every valid write frame, so downstream channels never see a partial update.
// Optional build macro: SPI_CFG_READBACK_EN enables register readback on spi_miso;
// without it spi_miso is held at 1 and read frames have no effect beyond validation.
module spi_cfg_ctrl #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned NBITS    = 10,
  parameter logic [15:0] ID_VALUE = 16'hD0C1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_sck,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic [NCH-1:0]       ch_en,
  output logic [NCH*16-1:0]    ch_div,
  output logic [NCH*2-1:0]     ch_mode,
  output logic [NCH*NBITS-1:0] ch_level,
  output logic                 cfg_strobe,
  output logic                 frame_err
);

  typedef enum logic [2:0] {StWaitCs, StIdle, StCmd, StData, StDone} state_e;

  localparam logic [NCH*16-1:0] DivRst = {NCH{16'd1000}};

  logic [2:0] sck_sync, cs_sync;
  logic [1:0] mosi_sync;
  logic       sck_rise, cs_rise, cs_fall, mosi_s;

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       ovr_q, ovr_d;
  logic       frame_ok, frame_bad;
  logic [23:0] sr_q;

  logic                 wr_en;
  logic [6:0]           wr_addr;
  logic [15:0]          wr_data;
  logic                 err_q, commit_q, strobe_q, frame_err_q;
  logic [NCH-1:0]       en_sh_q, en_act_q;
  logic [NCH*16-1:0]    div_sh_q, div_act_q;
  logic [NCH*2-1:0]     mode_sh_q, mode_act_q;
  logic [NCH*NBITS-1:0] lvl_sh_q, lvl_act_q;

  // Two-flop synchronisers plus a third flop for edge detection. cs_n resets low so a
  // frame in flight during reset cannot look like an idle bus to StWaitCs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[1:0], spi_sck};
      cs_sync   <= {cs_sync[1:0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign cs_rise  = cs_sync[1] & ~cs_sync[2];
  assign cs_fall  = ~cs_sync[1] & cs_sync[2];
  assign mosi_s   = mosi_sync[1];

  // Frame FSM state, bit counter, overrun flag and input shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StWaitCs;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      if ((state_q == StCmd || state_q == StData) && sck_rise && !cs_rise) begin
        sr_q <= {sr_q[22:0], mosi_s};
      end
    end
  end

  // Next-state logic; a cs_n rising edge takes priority over a coincident sck edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovr_d     = ovr_q;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    unique case (state_q)
      StWaitCs: if (cs_sync[1]) state_d = StIdle;
      StIdle: begin
        if (cs_fall) begin
          state_d = StCmd;
          cnt_d   = '0;
          ovr_d   = 1'b0;
        end
      end
      StCmd, StData: begin
        if (cs_rise) begin
          state_d   = StIdle;
          frame_bad = 1'b1;
        end else if (sck_rise) begin
          cnt_d = cnt_q + 5'd1;
          if (state_q == StCmd && cnt_q == 5'd7) state_d = StData;
          if (state_q == StData && cnt_q == 5'd23) state_d = StDone;
        end
      end
      StDone: begin
        if (cs_rise) begin
          state_d   = StIdle;
          frame_ok  = ~ovr_q;
          frame_bad = ovr_q;
        end else if (sck_rise) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = StWaitCs;
    endcase
  end

  assign wr_en   = frame_ok & sr_q[23];
  assign wr_addr = sr_q[22:16];
  assign wr_data = sr_q[15:0];

  // Shadow registers, sticky error and commit request on frame completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_sh_q     <= '0;
      div_sh_q    <= DivRst;
      mode_sh_q   <= '0;
      lvl_sh_q    <= '0;
      err_q       <= 1'b0;
      commit_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      commit_q    <= wr_en;
      frame_err_q <= frame_bad;
      if (frame_bad) err_q <= 1'b1;
      if (wr_en) begin
        if (wr_addr == 7'h01) begin
          if (wr_data[15]) err_q <= 1'b0;
          // Soft-clear wins over the enable field written in the same frame.
          if (wr_data[14]) begin
            en_sh_q   <= '0;
            div_sh_q  <= DivRst;
            mode_sh_q <= '0;
            lvl_sh_q  <= '0;
          end else begin
            en_sh_q <= wr_data[NCH-1:0];
          end
        end
        for (int i = 0; i < NCH; i++) begin
          if (wr_addr == 7'(2 + 2 * i)) div_sh_q[16*i +: 16] <= wr_data;
          if (wr_addr == 7'(3 + 2 * i)) begin
            mode_sh_q[2*i +: 2]        <= wr_data[13:12];
            lvl_sh_q[NBITS*i +: NBITS] <= wr_data[NBITS-1:0];
          end
        end
      end
    end
  end

  // Active outputs copy every shadow together, one clk after the frame is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_act_q   <= '0;
      div_act_q  <= DivRst;
      mode_act_q <= '0;
      lvl_act_q  <= '0;
      strobe_q   <= 1'b0;
    end else begin
      strobe_q <= commit_q;
      if (commit_q) begin
        en_act_q   <= en_sh_q;
        div_act_q  <= div_sh_q;
        mode_act_q <= mode_sh_q;
        lvl_act_q  <= lvl_sh_q;
      end
    end
  end

  assign ch_en      = en_act_q;
  assign ch_div     = div_act_q;
  assign ch_mode    = mode_act_q;
  assign ch_level   = lvl_act_q;
  assign cfg_strobe = strobe_q;
  assign frame_err  = frame_err_q;

`ifdef SPI_CFG_READBACK_EN
  logic [15:0] rd_data, miso_shift_q;
  logic [6:0]  rd_addr;
  logic        ld_miso, sck_fall;

  assign sck_fall = ~sck_sync[1] & sck_sync[2];
  // Address is complete on the 8th rising edge: seven bits in sr_q plus the live bit.
  assign rd_addr  = {sr_q[5:0], mosi_s};
  assign ld_miso  = (state_q == StCmd) && sck_rise && !cs_rise && (cnt_q == 5'd7);

  // Readback mux over the shadow bank (identical to the active bank between frames).
  always_comb begin
    rd_data = '0;
    if (rd_addr == 7'h00) begin
      rd_data = ID_VALUE;
    end else if (rd_addr == 7'h01) begin
      rd_data[15]      = err_q;
      rd_data[NCH-1:0] = en_sh_q;
    end
    for (int i = 0; i < NCH; i++) begin
      if (rd_addr == 7'(2 + 2 * i)) rd_data = div_sh_q[16*i +: 16];
      if (rd_addr == 7'(3 + 2 * i)) begin
        rd_data[13:12]      = mode_sh_q[2*i +: 2];
        rd_data[NBITS-1:0]  = lvl_sh_q[NBITS*i +: NBITS];
      end
    end
  end

  // MISO shifter: loaded after the command byte, advanced on sck falls, idles all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      miso_shift_q <= '1;
    end else if (ld_miso) begin
      miso_shift_q <= rd_data;
    end else if (state_q == StData && sck_fall && cnt_q >= 5'd9) begin
      miso_shift_q <= {miso_shift_q[14:0], 1'b1};
    end else if (state_q != StData) begin
      miso_shift_q <= '1;
    end
  end

  assign spi_miso = miso_shift_q[15];
`else
  logic unused_rb;
  assign unused_rb = ^{ID_VALUE, err_q};
  assign spi_miso  = 1'b1;
`endif

endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// Scoreboard bench for spi_cfg_ctrl: stimulus pushes expected strobes, frame errors and
// read words; a monitor pops and compares whenever the DUT presents one.
module tb_spi_cfg_ctrl;
  localparam int NCH   = 4;
  localparam int NBITS = 10;
  localparam int PH    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic spi_miso, cfg_strobe, frame_err;
  logic [NCH-1:0]       ch_en;
  logic [NCH*16-1:0]    ch_div;
  logic [NCH*2-1:0]     ch_mode;
  logic [NCH*NBITS-1:0] ch_level;

  spi_cfg_ctrl #(.NCH(NCH), .NBITS(NBITS), .ID_VALUE(16'hD0C1)) dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .ch_en(ch_en), .ch_div(ch_div), .ch_mode(ch_mode),
    .ch_level(ch_level), .cfg_strobe(cfg_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0]       en;
    logic [NCH*16-1:0]    div;
    logic [NCH*2-1:0]     mode;
    logic [NCH*NBITS-1:0] lvl;
  } snap_t;

  snap_t       m;
  snap_t       exp_strobe_q[$];
  logic [15:0] exp_read_q[$];
  int          exp_err_q[$];
  bit          done = 1'b0;
  int          tests = 0;
  int          fails = 0;

  function automatic snap_t reset_snap();
    snap_t s;
    s.en   = '0;
    s.div  = {NCH{16'd1000}};
    s.mode = '0;
    s.lvl  = '0;
    return s;
  endfunction

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void chk_outputs(input string tag, input snap_t s);
    chk({tag, "_en"}, 64'(ch_en), 64'(s.en));
    chk({tag, "_div"}, ch_div, s.div);
    chk({tag, "_mode"}, 64'(ch_mode), 64'(s.mode));
    chk({tag, "_level"}, 64'(ch_level), 64'(s.lvl));
  endfunction

  // ---------------- stimulus ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    spi_mosi = b;
    wait_clk(PH);
    spi_sck = 1'b1;
    wait_clk(PH);
    spi_sck = 1'b0;
  endtask

  task automatic spi_frame(input logic [31:0] f, input int n);
    spi_cs_n = 1'b0;
    wait_clk(PH);
    for (int i = n - 1; i >= 0; i--) send_bit(f[i]);
    wait_clk(PH);
    spi_cs_n = 1'b1;
    wait_clk(12);
  endtask

  task automatic wr(input logic [6:0] addr, input logic [15:0] data);
    if (addr == 7'h01) begin
      if (data[14]) m = reset_snap();
      else m.en = data[NCH-1:0];
    end
    for (int i = 0; i < NCH; i++) begin
      if (addr == 7'(2 + 2 * i)) m.div[16*i +: 16] = data;
      if (addr == 7'(3 + 2 * i)) begin
        m.mode[2*i +: 2] = data[13:12];
        m.lvl[NBITS*i +: NBITS] = data[NBITS-1:0];
      end
    end
    exp_strobe_q.push_back(m);
    spi_frame({8'h00, 1'b1, addr, data}, 24);
  endtask

  task automatic rd(input logic [6:0] addr, input logic [15:0] exp);
`ifdef SPI_CFG_READBACK_EN
    exp_read_q.push_back(exp);
`else
    exp_read_q.push_back(16'hFFFF);
`endif
    spi_frame({8'h00, 1'b0, addr, 16'h0000}, 24);
  endtask

  task automatic bad_frame(input logic [31:0] f, input int n);
    exp_err_q.push_back(n);
    spi_frame(f, n);
  endtask

  initial begin
    logic [31:0] f;
    m = reset_snap();
    wait_clk(5);
    rst = 1'b0;
    wait_clk(10);
    // 1: divider write to channel 0
    wr(7'h02, 16'h01F4);
    rd(7'h02, 16'h01F4);
    // 2: mode/level write and readback
    wr(7'h03, 16'h2200);
    rd(7'h03, 16'h2200);
    // 3: short frame, sticky error, write-1-to-clear
    f = {8'h00, 1'b1, 7'h02, 16'hABCD};
    bad_frame(f >> 11, 13);
    bad_frame(32'h0, 0);
    rd(7'h01, 16'h8000);
    wr(7'h01, 16'h8000);
    rd(7'h01, 16'h0000);
    // 4: overrun frame, other channel, soft-clear
    f = {6'h00, 1'b1, 7'h01, 16'h000F, 2'b11};
    bad_frame(f, 26);
    rd(7'h01, 16'h8000);
    wr(7'h08, 16'h1234);
    wr(7'h09, 16'h3155);
    rd(7'h08, 16'h1234);
    rd(7'h09, 16'h3155);
    wr(7'h01, 16'hC000);
    rd(7'h01, 16'h0000);
    rd(7'h02, 16'h03E8);
    // 5: reset in the middle of a write frame, remaining bits must be ignored
    wr(7'h05, 16'h0077);
    f = {8'h00, 1'b1, 7'h01, 16'h00FF};
    spi_cs_n = 1'b0;
    wait_clk(PH);
    for (int i = 23; i >= 14; i--) send_bit(f[i]);
    rst = 1'b1;
    m = reset_snap();
    wait_clk(3);
    rst = 1'b0;
    f = {8'h00, 1'b1, 7'h01, 16'h0005};
    for (int i = 23; i >= 0; i--) send_bit(f[i]);
    wait_clk(PH);
    spi_cs_n = 1'b1;
    wait_clk(12);
    wr(7'h01, 16'h000F);
    rd(7'h01, 16'h000F);
    // 6: ID, unmapped reads and writes
    rd(7'h00, 16'hD0C1);
    rd(7'h7F, 16'h0000);
    rd(7'h0A, 16'h0000);
    wr(7'h7F, 16'hFFFF);
    wait_clk(10);
    done = 1'b1;
  end

  // ---------------- monitor ----------------
  initial begin
    int          cyc = 0;
    int          cs_rise_cyc = 0;
    int          bits = 0;
    logic [7:0]  cmd = '0;
    logic [15:0] rdw = '0;
    logic        p_sck = 1'b0, p_cs = 1'b1, p_rst = 1'b1;
    snap_t       s;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (p_rst && !rst) begin
        chk_outputs("reset", reset_snap());
        chk("reset_strobe", 64'(cfg_strobe), 64'd0);
        chk("reset_frame_err", 64'(frame_err), 64'd0);
        chk("reset_miso", 64'(spi_miso), 64'd1);
      end
      if (!spi_cs_n && p_cs) begin
        bits = 0;
        cmd  = '0;
        rdw  = '0;
      end
      if (spi_sck && !p_sck && !spi_cs_n) begin
        bits++;
        if (bits <= 8) cmd = {cmd[6:0], spi_mosi};
        else if (bits <= 24) rdw = {rdw[14:0], spi_miso};
      end
      if (spi_cs_n && !p_cs) begin
        cs_rise_cyc = cyc;
        if (bits == 24 && !cmd[7]) begin
          if (exp_read_q.size() == 0) chk("read_unexpected", 64'd1, 64'd0);
          else chk("miso_read", 64'(rdw), 64'(exp_read_q.pop_front()));
        end
      end
      if (cfg_strobe) begin
        if (exp_strobe_q.size() == 0) begin
          chk("strobe_unexpected", 64'd1, 64'd0);
        end else begin
          s = exp_strobe_q.pop_front();
          chk("strobe_latency", 64'(cyc - cs_rise_cyc + 1), 64'd4);
          chk_outputs("commit", s);
        end
      end
      if (frame_err) begin
        if (exp_err_q.size() == 0) chk("frame_err_unexpected", 64'd1, 64'd0);
        else void'(exp_err_q.pop_front());
        chk_outputs("err_hold", m);
      end
      p_sck = spi_sck;
      p_cs  = spi_cs_n;
      p_rst = rst;
      if (done) begin
        chk_outputs("final", m);
        chk("pending_strobes", 64'(exp_strobe_q.size()), 64'd0);
        chk("pending_reads", 64'(exp_read_q.size()), 64'd0);
        chk("pending_errs", 64'(exp_err_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
      if (cyc > 40000) begin
        tests++;
        fails++;
        $display("FAIL timeout: got %0d cycles, expected under 40000", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  end

endmodule
